// File: rtl/keypad_scanner_if.sv
// Keypad-side lines and accepted-key outputs of the 4x4 keypad scanner.
interface keypad_scanner_if;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic [3:0] key_code;
  logic       data_ready;

  modport master (
    input  col_in,
    output row_out,
    output key_code,
    output data_ready
  );

  modport slave (
    output col_in,
    input  row_out,
    input  key_code,
    input  data_ready
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one-cold row scan, debounced press/release,
// one accepted key per press with no auto-repeat.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV        = 1000,
  parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
  input  logic             clk,
  input  logic             reset_in,
  keypad_scanner_if.master kp
);

  localparam int unsigned SCW = $clog2(SCAN_DIV);
  localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [SCW-1:0] SC_LAST = SCW'(SCAN_DIV - 1);
  // The sampling/detection cycle itself counts as the first stable cycle,
  // so the counter only has to cover the remaining DEBOUNCE_CYCLES-1.
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 2);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       row_q, row_d;
  logic [1:0]       col_q, col_d;
  logic [SCW-1:0]   scan_q, scan_d;
  logic [DBW-1:0]   deb_q, deb_d;
  logic [3:0]       key_q, key_d;
  logic             ready_q, ready_d;
  logic [3:0]       row_out_q, row_out_d;
  logic [3:0]       sync1, col_s;
  logic [1:0]       low_col;

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      sync1 <= '1;
      col_s <= '1;
    end else begin
      sync1 <= kp.col_in;
      col_s <= sync1;
    end
  end

  always_comb begin
    casez (col_s)
      4'b???0: low_col = 2'd0;
      4'b??01: low_col = 2'd1;
      4'b?011: low_col = 2'd2;
      default: low_col = 2'd3;
    endcase
  end

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      state_q   <= SCAN;
      row_q     <= '0;
      col_q     <= '0;
      scan_q    <= '0;
      deb_q     <= '0;
      key_q     <= '0;
      ready_q   <= 1'b0;
      row_out_q <= 4'b1110;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      scan_q    <= scan_d;
      deb_q     <= deb_d;
      key_q     <= key_d;
      ready_q   <= ready_d;
      row_out_q <= row_out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    scan_d  = scan_q;
    deb_d   = deb_q;
    key_d   = key_q;
    ready_d = 1'b0;
    unique case (state_q)
      SCAN: begin
        if (scan_q == SC_LAST) begin
          if (col_s != '1) begin
            col_d   = low_col;
            deb_d   = '0;
            state_d = DEBOUNCE;
          end else begin
            row_d  = row_q + 2'd1;
            scan_d = '0;
          end
        end else begin
          scan_d = scan_q + SCW'(1);
        end
      end
      DEBOUNCE: begin
        if (!col_s[col_q]) begin
          if (deb_q == DB_LAST) begin
            key_d   = {row_q, col_q};
            ready_d = 1'b1;
            deb_d   = '0;
            state_d = HELD;
          end else begin
            deb_d = deb_q + DBW'(1);
          end
        end else begin
          row_d   = row_q + 2'd1;
          scan_d  = '0;
          deb_d   = '0;
          state_d = SCAN;
        end
      end
      HELD: begin
        if (col_s[col_q]) begin
          deb_d   = '0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (col_s[col_q]) begin
          if (deb_q == DB_LAST) begin
            row_d   = row_q + 2'd1;
            scan_d  = '0;
            deb_d   = '0;
            state_d = SCAN;
          end else begin
            deb_d = deb_q + DBW'(1);
          end
        end else begin
          deb_d   = '0;
          state_d = HELD;
        end
      end
      default: state_d = SCAN;
    endcase
    row_out_d = ~(4'b0001 << row_d);
  end

  assign kp.row_out    = row_out_q;
  assign kp.key_code   = key_q;
  assign kp.data_ready = ready_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: simulated key matrix, run-length reference model,
// table-driven presses, hand-written corner sequences and random stimulus.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DB = 8;

  logic        clk;
  logic        reset_in;
  logic [15:0] pressed;
  int          total;
  int          bad;

  keypad_scanner_if kif ();

  keypad_scanner #(
    .SCAN_DIV       (SD),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk     (clk),
    .reset_in(reset_in),
    .kp      (kif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A pressed key at (r,c) pulls column c low while row r is driven low.
  function automatic logic [3:0] cols_of(input logic [15:0] p, input logic [3:0] ro);
    logic [3:0] c;
    c = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++)
        if (!ro[r] && p[r*4+k]) c[k] = 1'b0;
    return c;
  endfunction

  assign kif.col_in = cols_of(pressed, kif.row_out);

  function automatic logic [15:0] key_bit(input int r, input int c);
    logic [15:0] one;
    one = 16'd1;
    return one << (r * 4 + c);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: keys are judged by how many consecutive synchronized
  // samples have been low (press) or high (release).
  logic [1:0] m_row, m_c;
  int         m_slot, m_run, m_rel;
  bit         m_locked, m_acc, m_dr;
  logic [3:0] m_key, m_s1, m_s2;
  int         edge_n, lock_edge, dr_edge, npulse;

  task automatic model_reset();
    m_row = 2'd0; m_c = 2'd0; m_slot = 0; m_run = 0; m_rel = 0;
    m_locked = 0; m_acc = 0; m_dr = 0; m_key = 4'h0;
    m_s1 = 4'hF; m_s2 = 4'hF;
  endtask

  task automatic model_unlock();
    m_locked = 0;
    m_row    = m_row + 2'd1;
    m_slot   = 0;
  endtask

  task automatic model_edge(input logic [3:0] col_pre);
    logic [3:0] cs;
    cs   = m_s2;
    m_dr = 0;
    if (!m_locked) begin
      if (m_slot == SD - 1) begin
        if (cs != 4'hF) begin
          m_locked = 1; m_acc = 0; m_run = 1; lock_edge = edge_n;
          for (int i = 3; i >= 0; i--) if (!cs[i]) m_c = 2'(i);
        end else begin
          m_row  = m_row + 2'd1;
          m_slot = 0;
        end
      end else begin
        m_slot++;
      end
    end else if (!m_acc) begin
      if (!cs[m_c]) begin
        m_run++;
        if (m_run == DB) begin
          m_acc = 1; m_rel = 0; m_key = {m_row, m_c}; m_dr = 1;
        end
      end else begin
        model_unlock();
      end
    end else begin
      if (cs[m_c]) begin
        m_rel++;
        if (m_rel == DB) model_unlock();
      end else begin
        m_rel = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = col_pre;
  endtask

  task automatic step();
    logic [3:0] cp, er, ek;
    logic       ed;
    @(negedge clk);
    cp = kif.col_in;
    @(posedge clk);
    edge_n++;
    model_edge(cp);
    #1;
    er = 4'b0001 << m_row;
    er = ~er;
    ek = m_key;
    ed = m_dr;
    chk("row_out", kif.row_out, er);
    chk("key_code", kif.key_code, ek);
    chk("data_ready", kif.data_ready, ed);
    if (kif.data_ready === 1'b1) begin
      npulse++;
      dr_edge = edge_n;
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  typedef struct {
    string       nm;
    logic [15:0] keys;
    int          hold;
    logic [3:0]  exp_key;
    int          exp_pulses;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] v;
    bit         seen;

    vecs[0] = '{"key5",     key_bit(1, 1),                 40, 4'b0101, 1};
    vecs[1] = '{"key1_3",   key_bit(0, 0) | key_bit(0, 2), 40, 4'b0000, 1};
    vecs[2] = '{"key8_9",   key_bit(2, 1) | key_bit(2, 2), 40, 4'b1001, 1};
    vecs[3] = '{"key0",     key_bit(3, 1),                 40, 4'b1101, 1};
    vecs[4] = '{"keyA",     key_bit(0, 3),                 40, 4'b0011, 1};

    total = 0; bad = 0; edge_n = 0; npulse = 0; lock_edge = 0; dr_edge = 0;
    pressed  = 16'h0;
    reset_in = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_row_out", kif.row_out, 4'b1110);
    chk("rst_key_code", kif.key_code, 4'b0000);
    chk("rst_data_ready", kif.data_ready, 1'b0);
    @(posedge clk);
    #3 reset_in = 1'b1;

    // Idle keypad: 16 row changes in 64 edges land back on row 0.
    npulse = 0;
    steps(64);
    chk("idle_pulses", npulse, 0);
    chk("idle_row_wrap", kif.row_out, 4'b1110);
    chk("idle_key", kif.key_code, 4'b0000);

    foreach (vecs[i]) begin
      npulse = 0; lock_edge = -100; dr_edge = 0;
      pressed = vecs[i].keys;
      steps(vecs[i].hold);
      chk({vecs[i].nm, "_latency"}, dr_edge + 1 - lock_edge, DB);
      pressed = 16'h0;
      steps(40);
      chk({vecs[i].nm, "_pulses"}, npulse, vecs[i].exp_pulses);
      chk({vecs[i].nm, "_code"}, kif.key_code, vecs[i].exp_key);
    end

    // "#" bounces once inside the debounce window, then settles.
    npulse = 0;
    pressed = key_bit(3, 2);
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      seen = m_locked;
    end
    chk("bounce_lock_seen", seen, 1'b1);
    steps(2);
    pressed = 16'h0;
    step();
    chk("bounce_no_early_pulse", npulse, 0);
    pressed = key_bit(3, 2);
    steps(40);
    pressed = 16'h0;
    steps(40);
    chk("bounce_pulses", npulse, 1);
    chk("bounce_code", kif.key_code, 4'b1110);

    // "D" held long, release with a short re-bounce, then clean release.
    npulse = 0;
    pressed = key_bit(3, 3);
    steps(200);
    pressed = 16'h0;
    steps(3);
    pressed = key_bit(3, 3);
    steps(2);
    pressed = 16'h0;
    steps(40);
    chk("d_pulses", npulse, 1);
    chk("d_code", kif.key_code, 4'b1111);

    // Reset pulse while "7" is held.
    npulse = 0;
    pressed = key_bit(2, 0);
    steps(40);
    chk("k7_first_pulse", npulse, 1);
    @(negedge clk);
    #2 reset_in = 1'b0;
    #1;
    chk("k7_rst_row_out", kif.row_out, 4'b1110);
    chk("k7_rst_key_code", kif.key_code, 4'b0000);
    chk("k7_rst_data_ready", kif.data_ready, 1'b0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #3 reset_in = 1'b1;
    npulse = 0;
    steps(50);
    chk("k7_after_rst_pulses", npulse, 1);
    chk("k7_after_rst_code", kif.key_code, 4'b1000);
    pressed = 16'h0;
    steps(40);

    // Random presses, chords and bounces, every cycle checked by the model.
    for (int ph = 0; ph < 40; ph++) begin
      logic [15:0] ks;
      int          hold;
      ks = key_bit($urandom_range(0, 3), $urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) ks = ks | key_bit($urandom_range(0, 3), $urandom_range(0, 3));
      hold = $urandom_range(1, 50);
      for (int c = 0; c < hold; c++) begin
        pressed = ($urandom_range(0, 7) == 0) ? 16'h0 : ks;
        step();
      end
      pressed = 16'h0;
      steps($urandom_range(0, 30));
    end
    pressed = 16'h0;
    steps(40);
    v = kif.row_out;
    chk("final_row_onecold", $countones(~v), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 1000, clk cycles each row is driven during scanning; SHALL be >= 4.
REQ-002 Parameter DEBOUNCE_CYCLES, default 20000, consecutive stable cycles required to accept a press or a release; SHALL be >= 2.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset_in  input  1  asynchronous, active-low reset.
REQ-005 col_in  input  4  keypad column lines, active-low, externally pulled up, asynchronous to clk.
REQ-006 row_out  output  4  keypad row drive, one-cold (active-low), registered.
REQ-007 key_code  output  4  accepted key, {row[1:0], col[1:0]}, registered, held until next accepted key.
REQ-008 data_ready  output  1  one-cycle pulse, high in the first cycle key_code shows a newly accepted key.

Function
REQ-009 Key map SHALL be: row0 = 1,2,3,A; row1 = 4,5,6,B; row2 = 7,8,9,C; row3 = *,0,#,D; col index 0..3 left to right (e.g. 0 = 4'b1101, # = 4'b1110, D = 4'b1111).
REQ-010 col_in SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value col_s.
REQ-011 States SHALL be SCAN, DEBOUNCE, HELD, RELEASE.
REQ-012 SCAN: row_out drives row r for SCAN_DIV cycles, then advances to r+1, wrapping 3 -> 0; scan counter restarts at 0 on each row change.
REQ-013 SCAN: col_s is sampled only in the last cycle of a row slot (scan counter = SCAN_DIV-1); if any bit is low, the lowest low column index c is latched with r, the row is frozen, and the state goes to DEBOUNCE.
REQ-014 DEBOUNCE: counter starts at 0 and increments each cycle col_s[c] is low; when the counter reaches DEBOUNCE_CYCLES-1 with col_s[c] still low, key_code <= {r,c}, data_ready pulses for 1 cycle, and the state goes to HELD.
REQ-015 DEBOUNCE: if col_s[c] is high in any cycle, the press is rejected with no output change, and the state returns to SCAN at row r+1 (with wrap) with the scan counter at 0.
REQ-016 HELD: row r stays driven; no further data_ready (no auto-repeat); other keys are ignored; when col_s[c] goes high, the state goes to RELEASE with the counter at 0.
REQ-017 RELEASE: counter increments each cycle col_s[c] is high; if col_s[c] goes low, the state returns to HELD; at DEBOUNCE_CYCLES-1 the state goes to SCAN at row r+1 with the scan counter at 0.
REQ-018 Simultaneous presses in the same row: the lowest column index wins; presses in different rows: the first row sampled wins.
REQ-019 A key held through reset release SHALL be accepted once, via the normal SCAN/DEBOUNCE path.
REQ-020 Total accept latency from the sampling cycle SHALL be exactly DEBOUNCE_CYCLES cycles for a clean press.
REQ-021 Counters SHALL be sized with $clog2 of their parameter and SHALL never wrap.

Reset
REQ-022 While reset_in = 0: state = SCAN, row_out = 4'b1110, key_code = 4'b0000, data_ready = 0, all counters = 0, synchronizer flops = 4'b1111.
REQ-023 Reset asserted mid-DEBOUNCE, mid-HELD or mid-RELEASE SHALL abort immediately with no data_ready pulse; scanning restarts at row 0 on the first clk edge after deassertion.

Verification (SCAN_DIV = 4, DEBOUNCE_CYCLES = 8)
REQ-024 Clean press of "5" (row1, col1 low while row_out = 4'b1101) held for 40 cycles -> exactly one data_ready pulse, key_code = 4'b0101, pulse 8 cycles after the sampling cycle.
REQ-025 Bounce on "#": col2 low 3 cycles, high 1 cycle, then low 40 cycles -> first attempt rejected, scan resumes at row 0, later single pulse with key_code = 4'b1110.
REQ-026 "1" and "3" pressed together (row0, col0 and col2) -> single pulse, key_code = 4'b0000.
REQ-027 "D" held 200 cycles, then released with a 2-cycle re-bounce, then released clean -> one pulse only; scanning resumes at row 0 after 8 clean release cycles; row_out cycles 1110, 1101, 1011, 0111.
REQ-028 reset_in pulsed low during HELD of "7" -> outputs return to reset values asynchronously; after release with "7" still held, one new pulse with key_code = 4'b1000.
REQ-029 Idle keypad for 64 cycles after reset -> row_out rotates every 4 cycles with wrap; data_ready stays 0; key_code stays 4'b0000.
